// File: rtl/psum_collector.sv
// psum_collector: accumulates PE-cluster partial sums for one output row,
// then drains the row over valid/ready. Macro PSUM_SAT_EN: saturating adds.
module psum_collector #(
   parameter int DATA_WIDTH      = 16,
   parameter int MAX_OFMAP_WIDTH = 32,
   parameter int MAX_CHANNEL     = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [$clog2(MAX_OFMAP_WIDTH):0]   i_ofmap_width,
   input  logic [$clog2(MAX_CHANNEL):0]       i_channel_num,
   input  logic                               i_start,
   input  logic [DATA_WIDTH-1:0]              i_peout_data,
   input  logic                               i_peout_valid,
   output logic [DATA_WIDTH-1:0]              o_ofmap_data,
   output logic                               o_ofmap_valid,
   input  logic                               i_ofmap_ready,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_overrun
);

   localparam int WW = $clog2(MAX_OFMAP_WIDTH) + 1;
   localparam int CW = $clog2(MAX_CHANNEL) + 1;
   localparam int IW = (MAX_OFMAP_WIDTH > 1) ?
                       $clog2(MAX_OFMAP_WIDTH) : 1;

`ifdef PSUM_SAT_EN
   localparam logic [DATA_WIDTH-1:0] SMAX =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SMIN =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN
   } state_t;

   state_t                state;
   logic [WW-1:0]         width_q;
   logic [CW-1:0]         ch_num_q;
   logic [CW-1:0]         ch_cnt;
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         rd_idx;
   logic [IW-1:0]         rd_nxt;

   logic [DATA_WIDTH-1:0] mem [MAX_OFMAP_WIDTH];

   logic [DATA_WIDTH-1:0] old_val;
   logic [DATA_WIDTH-1:0] sum_raw;
   logic [DATA_WIDTH-1:0] sum_val;
   logic [DATA_WIDTH-1:0] wr_val;

   logic                  start_ok;
   logic                  accept;
   logic                  wr_last;
   logic                  ch_last;
   logic                  rd_last;

   // Start qualification, index bookkeeping and the next drain address
   always_comb begin
      start_ok = (i_ofmap_width != '0)
              && (i_ofmap_width <= WW'(MAX_OFMAP_WIDTH))
              && (i_channel_num != '0)
              && (i_channel_num <= CW'(MAX_CHANNEL));
      accept   = (state == ACCUM) && i_peout_valid;
      wr_last  = (WW'(wr_idx) == (width_q - WW'(1)));
      ch_last  = (ch_cnt == (ch_num_q - CW'(1)));
      rd_last  = (WW'(rd_idx) == (width_q - WW'(1)));
      rd_nxt   = rd_idx + IW'(1);
   end

   // Read-modify-write value; async read lets width==1 run at full rate
   always_comb begin
      old_val = mem[wr_idx];
      sum_raw = old_val + i_peout_data;
      sum_val = sum_raw;
`ifdef PSUM_SAT_EN
      // Same-sign operands with a flipped result sign mean overflow
      if ((old_val[DATA_WIDTH-1] == i_peout_data[DATA_WIDTH-1]) &&
          (sum_raw[DATA_WIDTH-1] != old_val[DATA_WIDTH-1])) begin
         sum_val = old_val[DATA_WIDTH-1] ? SMIN : SMAX;
      end
`endif
      wr_val = (ch_cnt == '0) ? i_peout_data : sum_val;
   end

   // Accumulation buffer write port; contents need no reset
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         mem[wr_idx] <= wr_val;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         width_q       <= '0;
         ch_num_q      <= '0;
         ch_cnt        <= '0;
         wr_idx        <= '0;
         rd_idx        <= '0;
         o_ofmap_data  <= '0;
         o_ofmap_valid <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_peout_valid && (state != ACCUM)) begin
            o_overrun <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (i_start && start_ok) begin
                  width_q  <= i_ofmap_width;
                  ch_num_q <= i_channel_num;
                  ch_cnt   <= '0;
                  wr_idx   <= '0;
                  rd_idx   <= '0;
                  o_busy   <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (i_peout_valid) begin
                  if (wr_last) begin
                     wr_idx <= '0;
                     ch_cnt <= ch_cnt + CW'(1);
                     if (ch_last) begin
                        // Forward the fresh write when it lands on index 0
                        o_ofmap_data  <= (wr_idx == '0) ? wr_val : mem[0];
                        o_ofmap_valid <= 1'b1;
                        rd_idx        <= '0;
                        state         <= DRAIN;
                     end
                  end else begin
                     wr_idx <= wr_idx + IW'(1);
                  end
               end
            end
            DRAIN: begin
               if (o_ofmap_valid && i_ofmap_ready) begin
                  if (rd_last) begin
                     o_ofmap_valid <= 1'b0;
                     o_done        <= 1'b1;
                     o_busy        <= 1'b0;
                     rd_idx        <= '0;
                     state         <= IDLE;
                  end else begin
                     rd_idx       <= rd_nxt;
                     o_ofmap_data <= mem[rd_nxt];
                  end
               end
            end
            default: begin
               o_ofmap_valid <= 1'b0;
               o_busy        <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: table vectors, hand sequences and randomized rows
// checked against an arithmetic model of row accumulation.
module tb_psum_collector;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  ofmap_width;
   logic [6:0]  channel_num;
   logic        start;
   logic [15:0] peout_data;
   logic        peout_valid;
   logic [15:0] ofmap_data;
   logic        ofmap_valid;
   logic        ofmap_ready;
   logic        busy;
   logic        done;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int rdy_pat[$];

   typedef struct {
      int w;
      int ch;
      int n;
      int d[8];
      int e[4];
      int rmode;
   } vec_t;

   vec_t tbl[6];

   psum_collector dut (
      .clk           (clk),
      .reset         (reset),
      .i_ofmap_width (ofmap_width),
      .i_channel_num (channel_num),
      .i_start       (start),
      .i_peout_data  (peout_data),
      .i_peout_valid (peout_valid),
      .o_ofmap_data  (ofmap_data),
      .o_ofmap_valid (ofmap_valid),
      .i_ofmap_ready (ofmap_ready),
      .o_busy        (busy),
      .o_done        (done),
      .o_overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   function automatic int sdata();
      return int'($signed(ofmap_data));
   endfunction

   // One accumulation step of the reference: plain integer arithmetic
   function automatic int fold(input int acc, input int d, input bit first);
      int s;
      if (first) return d;
      s = acc + d;
`ifdef PSUM_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = s & 32'h0000FFFF;
      if (s >= 32768) s = s - 65536;
`endif
      return s;
   endfunction

   task automatic run_row(input string tag, input int w, input int ch,
                          input int d[$], input int e[$],
                          input int rmode, input bit gaps);
      int idx;
      int cyc;
      bit stall;
      int prev;
      bit r;
      @(negedge clk);
      ofmap_width = 6'(w);
      channel_num = 7'(ch);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, int'(busy), 1);
      foreach (d[k]) begin
         peout_valid = 1'b1;
         peout_data  = 16'(d[k]);
         @(negedge clk);
         peout_valid = 1'b0;
         if (gaps && (k != d.size() - 1))
            repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk({tag, "_valid_rise"}, int'(ofmap_valid), 1);
      idx = 0;
      cyc = 0;
      stall = 1'b0;
      prev = 0;
      while ((idx < w) && (cyc < 400)) begin
         case (rmode)
            0: r = 1'b1;
            1: r = (cyc < rdy_pat.size()) ? (rdy_pat[cyc] != 0) : 1'b1;
            default: r = 1'($urandom_range(0, 1));
         endcase
         ofmap_ready = r;
         if (stall) begin
            chk({tag, "_stall_data"}, sdata(), prev);
            chk({tag, "_stall_valid"}, int'(ofmap_valid), 1);
         end
         if (rmode == 0) chk({tag, "_rate"}, int'(ofmap_valid), 1);
         if (ofmap_valid && r) begin
            chk({tag, "_beat"}, sdata(), e[idx]);
            idx++;
         end
         stall = ofmap_valid && !r;
         prev = sdata();
         @(negedge clk);
         cyc++;
      end
      ofmap_ready = 1'b0;
      if (idx < w) chk({tag, "_drain_timeout"}, idx, w);
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_idle_busy"}, int'(busy), 0);
      chk({tag, "_idle_valid"}, int'(ofmap_valid), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, int'(done), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_valid"}, int'(ofmap_valid), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
      chk({tag, "_data"}, int'(ofmap_data), 0);
   endtask

   task automatic bad_start(input string tag, input int w, input int ch);
      @(negedge clk);
      ofmap_width = 6'(w);
      channel_num = 7'(ch);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_ignored"}, int'(busy), 0);
   endtask

   initial begin
      int d[$];
      int e[$];
      int acc[];
      int w;
      int ch;

      reset = 1'b1;
      ofmap_width = '0;
      channel_num = '0;
      start = 1'b0;
      peout_data = '0;
      peout_valid = 1'b0;
      ofmap_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      bad_start("w0", 0, 1);
      bad_start("w33", 33, 1);
      bad_start("ch0", 1, 0);
      bad_start("ch65", 1, 65);

      tbl[0].w = 4; tbl[0].ch = 2; tbl[0].n = 8; tbl[0].rmode = 0;
      tbl[0].d = '{1, 2, 3, 4, 10, 20, 30, 40};
      tbl[0].e = '{11, 22, 33, 44};
      tbl[1].w = 3; tbl[1].ch = 1; tbl[1].n = 3; tbl[1].rmode = 1;
      tbl[1].d = '{5, 6, 7, 0, 0, 0, 0, 0};
      tbl[1].e = '{5, 6, 7, 0};
      tbl[2].w = 1; tbl[2].ch = 3; tbl[2].n = 3; tbl[2].rmode = 0;
      tbl[2].d = '{100, 200, 300, 0, 0, 0, 0, 0};
      tbl[2].e = '{600, 0, 0, 0};
      tbl[3].w = 1; tbl[3].ch = 2; tbl[3].n = 2; tbl[3].rmode = 0;
      tbl[3].d = '{30000, 10000, 0, 0, 0, 0, 0, 0};
`ifdef PSUM_SAT_EN
      tbl[3].e = '{32767, 0, 0, 0};
`else
      tbl[3].e = '{-25536, 0, 0, 0};
`endif
      tbl[4].w = 1; tbl[4].ch = 2; tbl[4].n = 2; tbl[4].rmode = 0;
      tbl[4].d = '{-30000, -10000, 0, 0, 0, 0, 0, 0};
`ifdef PSUM_SAT_EN
      tbl[4].e = '{-32768, 0, 0, 0};
`else
      tbl[4].e = '{25536, 0, 0, 0};
`endif
      tbl[5].w = 2; tbl[5].ch = 2; tbl[5].n = 4; tbl[5].rmode = 0;
      tbl[5].d = '{-5, 7, 3, -9, 0, 0, 0, 0};
      tbl[5].e = '{-2, -2, 0, 0};
      rdy_pat = '{0, 1, 0, 0, 1, 1};

      foreach (tbl[t]) begin
         d = {};
         e = {};
         for (int k = 0; k < tbl[t].n; k++) d.push_back(tbl[t].d[k]);
         for (int k = 0; k < tbl[t].w; k++) e.push_back(tbl[t].e[k]);
         run_row($sformatf("vec%0d", t), tbl[t].w, tbl[t].ch, d, e,
                 tbl[t].rmode, 1'b0);
      end
      chk("no_overrun_yet", int'(overrun), 0);

      // Pulse while idle: flagged, row afterwards is unaffected
      @(negedge clk);
      peout_valid = 1'b1;
      peout_data = 16'd123;
      @(negedge clk);
      peout_valid = 1'b0;
      chk("overrun_idle", int'(overrun), 1);
      run_row("after_ovr", 2, 1, '{3, 9}, '{3, 9}, 0, 1'b0);
      chk("overrun_sticky", int'(overrun), 1);

      // Pulse during drain is dropped and does not disturb the row
      @(negedge clk);
      ofmap_width = 6'd2;
      channel_num = 7'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      peout_valid = 1'b1;
      peout_data = 16'd5;
      @(negedge clk);
      peout_data = 16'd6;
      @(negedge clk);
      peout_data = 16'd77;
      @(negedge clk);
      peout_valid = 1'b0;
      chk("drain_ovr_data0", sdata(), 5);
      ofmap_ready = 1'b1;
      @(negedge clk);
      chk("drain_ovr_data1", sdata(), 6);
      @(negedge clk);
      ofmap_ready = 1'b0;
      chk("drain_ovr_done", int'(done), 1);

      // Reset in the middle of accumulation
      @(negedge clk);
      ofmap_width = 6'd4;
      channel_num = 7'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         peout_valid = 1'b1;
         peout_data = 16'(k + 1);
         @(negedge clk);
      end
      peout_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_zero("rst_accum");
      reset = 1'b0;
      run_row("post_rst", 2, 1, '{7, 8}, '{7, 8}, 0, 1'b0);

      // Reset while a word is waiting in drain
      @(negedge clk);
      ofmap_width = 6'd3;
      channel_num = 7'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         peout_valid = 1'b1;
         peout_data = 16'(k + 1);
         @(negedge clk);
      end
      peout_valid = 1'b0;
      chk("rst_drain_pre", int'(ofmap_valid), 1);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("rst_drain");
      reset = 1'b0;

      // Randomized rows against the reference model
      for (int i = 0; i < 24; i++) begin
         w = $urandom_range(1, 6);
         ch = $urandom_range(1, 4);
         if (i == 5) begin w = 32; ch = 2; end
         if (i == 11) begin w = 1; ch = 64; end
         if (i == 17) begin w = 32; ch = 64; end
         d = {};
         e = {};
         acc = new[w];
         for (int p = 0; p < ch; p++) begin
            for (int k = 0; k < w; k++) begin
               int v;
               v = (i % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                : int'($urandom_range(0, 200)) - 100;
               d.push_back(v);
               acc[k] = fold(acc[k], v, p == 0);
            end
         end
         for (int k = 0; k < w; k++) e.push_back(acc[k]);
         run_row($sformatf("rnd%0d", i), w, ch, d, e, 2, 1'(i % 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
